// File: rtl/net1_pkg.sv
// Shared types and constants for the net1 sweep controller.
// Holds the FSM state encoding and the stimulus/response/count widths.
package net1_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} sweep_state_t;

  localparam int NUM_COMBOS = 16;
  localparam int IN_W       = 4;
  localparam int OUT_W      = 3;
  localparam int ONES_W     = 5;

  localparam logic [IN_W-1:0] LAST_COMBO = IN_W'(NUM_COMBOS - 1);

endpackage

// File: rtl/net1_sweep_ctrl_if.sv
// Result stream of the net1 sweep controller: one valid/ready beat per combination.
// The controller is the master; the result consumer is the slave.
interface net1_sweep_ctrl_if;
  import net1_pkg::*;

  logic             result_valid_o;
  logic             result_ready_i;
  logic [IN_W-1:0]  result_index_o;
  logic [OUT_W-1:0] result_xyz_o;

  modport master (
    output result_valid_o,
    output result_index_o,
    output result_xyz_o,
    input  result_ready_i
  );

  modport slave (
    input  result_valid_o,
    input  result_index_o,
    input  result_xyz_o,
    output result_ready_i
  );

endinterface

// File: rtl/net1_sweep_ctrl_hold_timer.sv
// Clearable up-counter that flags the last cycle of a combination's hold window.
// HOLD_CYCLES must be in 1..255 so the terminal value fits the 8-bit count.
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [7:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign terminal = (count == 8'(HOLD_CYCLES - 1));

endmodule

// File: rtl/net1_sweep_ctrl.sv
// Clocked sweep of the net1 network over all 16 input combinations, one
// back-pressurable result per combination plus per-output ones-counts.
module net1_sweep_ctrl
  import net1_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [IN_W-1:0]    abcd_o,
  input  logic [OUT_W-1:0]   xyz_i,
  net1_sweep_ctrl_if.master  result,
  output logic [ONES_W-1:0]  x_ones_o,
  output logic [ONES_W-1:0]  y_ones_o,
  output logic [ONES_W-1:0]  z_ones_o
);

  sweep_state_t state;
  logic         hold_clear;
  logic         hold_enable;
  logic         hold_done;

  // The timer sits at zero outside DRIVE, so every DRIVE entry starts a fresh hold window.
  assign hold_clear  = (state != DRIVE);
  assign hold_enable = (state == DRIVE);

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (hold_clear),
    .enable   (hold_enable),
    .terminal (hold_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      abcd_o                <= '0;
      result.result_valid_o <= 1'b0;
      result.result_index_o <= '0;
      result.result_xyz_o   <= '0;
      x_ones_o              <= '0;
      y_ones_o              <= '0;
      z_ones_o              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= DRIVE;
            busy_o   <= 1'b1;
            abcd_o   <= '0;
            x_ones_o <= '0;
            y_ones_o <= '0;
            z_ones_o <= '0;
          end
        end
        DRIVE: begin
          if (hold_done) begin
            state                 <= EMIT;
            result.result_valid_o <= 1'b1;
            result.result_xyz_o   <= xyz_i;
            result.result_index_o <= abcd_o;
            x_ones_o              <= x_ones_o + ONES_W'(xyz_i[2]);
            y_ones_o              <= y_ones_o + ONES_W'(xyz_i[1]);
            z_ones_o              <= z_ones_o + ONES_W'(xyz_i[0]);
          end
        end
        EMIT: begin
          // Everything stays frozen until the consumer takes the beat.
          if (result.result_ready_i) begin
            result.result_valid_o <= 1'b0;
            if (result.result_index_o == LAST_COMBO) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state  <= DRIVE;
              abcd_o <= abcd_o + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/net1_sweep_ctrl.md
# net1_sweep_ctrl

Synchronous sequencer that drives the combinational `net1` network (inputs a, b, c, d; outputs x, y, z) through all 16 input combinations. Each combination is held for a programmable number of cycles, the settled outputs are sampled, and one result per combination is streamed out over a valid/ready handshake. Per-output ones-counts are accumulated over the sweep. The block sits between a control/host side (start, results) and one `net1` instance, and replaces open-loop, timing-based stimulus with a clocked, back-pressurable sweep.

## Interface
Parameters:
- HOLD_CYCLES, 4: cycles each combination is driven before sampling. Legal range is 1 to 255.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  begins a sweep when sampled high in IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse in the DONE state
- abcd_o  out  4  net1 stimulus: bit 3 = a, bit 2 = b, bit 1 = c, bit 0 = d
- xyz_i  in  3  net1 response: bit 2 = x, bit 1 = y, bit 0 = z
- result_valid_o  out  1  a result is available
- result_ready_i  in  1  consumer accepts the result
- result_index_o  out  4  combination the result belongs to
- result_xyz_o  out  3  sampled xyz for that combination
- x_ones_o, y_ones_o, z_ones_o  out  5 each  number of combinations in the current/last sweep where the output was 1 (range 0 to 16)

## Operation
- States: IDLE, DRIVE, EMIT, DONE.
- IDLE:
  - start_i=1 moves to DRIVE.
  - On that transition: abcd_o=0, hold counter=0, all ones-counters cleared.
- DRIVE:
  - The hold counter increments every cycle.
  - In the cycle where hold counter = HOLD_CYCLES-1, the next edge does all of the following: latches xyz_i into result_xyz_o, latches abcd_o into result_index_o, adds each xyz bit to its ones-counter, and moves to EMIT.
- EMIT:
  - result_valid_o=1.
  - result_valid_o=1 and result_ready_i=1 together form a transfer.
  - On transfer with index 15: move to DONE.
  - On transfer with any other index: abcd_o increments, hold counter=0, move to DRIVE.
  - Without transfer: stay in EMIT. All outputs are held stable; valid is never withdrawn.
- DONE: done_o=1 for exactly one cycle, then move to IDLE.
- abcd_o is stable throughout DRIVE and EMIT. It changes only on the DRIVE entry edge.
- abcd_o keeps its last value (15) in IDLE after a sweep.
- start_i is ignored outside IDLE. A start_i held high through DONE starts a new sweep from the following IDLE cycle.
- Ones-counters hold their values after DONE until the next start.
- Arithmetic is unsigned. Ones-counters cannot overflow (maximum 16 fits in 5 bits). abcd_o never wraps within a sweep.

## Timing
- Reset (asynchronous, any time, including mid-sweep):
  - State returns to IDLE.
  - abcd_o=0, result_index_o=0, result_xyz_o=0, all ones-counters=0.
  - result_valid_o=0, busy_o=0, done_o=0.
  - An in-flight result is discarded.
- Sampling occurs exactly HOLD_CYCLES edges after abcd_o takes a new value.
- Per-combination cost is HOLD_CYCLES+1 cycles when ready is held high; every stalled cycle adds one.
- With result_ready_i held high and start sampled at edge E0, done_o is high in the cycle following edge E0 + 16·(HOLD_CYCLES+1).
- busy_o rises on the edge after start is sampled and falls on the edge leaving DONE.
- All outputs are registered. There is no combinational path from result_ready_i or xyz_i to any output.

## Structure
- Shared package `net1_pkg` holds:
  - the state enum type `sweep_state_t` (IDLE, DRIVE, EMIT, DONE)
  - constant NUM_COMBOS=16
  - constants for input width (4), output width (3) and ones-counter width (5)
- One sub-module is natural: `hold_timer`, a loadable up-counter with a terminal-count flag, parameterised by HOLD_CYCLES. Everything else stays in the top-level FSM.

## Test plan
The bench replaces net1 with a stub computing x=a&b, y=c|d, z=a^d. HOLD_CYCLES=4 unless stated.
- Free-running sweep, ready=1, start pulse at E0: results delivered for index 0..15 in order. The result for index 13 (a=1, b=1, c=0, d=1) is xyz=110. Final counts x=4, y=12, z=8. done_o pulses exactly once, at E0+80.
- Back-pressure: ready low for 7 cycles at index 5. result_valid_o stays high, index/xyz/abcd_o are held constant, and done_o is delayed by exactly 7 cycles.
- HOLD_CYCLES=1: each combination takes 2 cycles; done_o arrives at E0+32; final counts are the same as the free-running sweep.
- start_i pulsed again mid-sweep: ignored. After done_o, a new start clears the counts to 0 at the DRIVE entry and the sweep repeats identically.
- reset_n asserted during EMIT at index 9: all outputs go to their reset values immediately; a start after release sweeps from index 0.
- start_i held high continuously: back-to-back sweeps with exactly one IDLE cycle between done_o and the next DRIVE.
